// File: rtl/sm_hex_display_n.sv
// Multiplexed seven-segment driver: internal refresh prescaler, per-frame input shadowing,
// hex decode, per-digit dots and leading-zero blanking. Optional dimming: HEX_DISPLAY_BRIGHTNESS_EN.
module sm_hex_display_n #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE_W     = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clkIn,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame_start
);

    localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'b0111111;
            4'h1:    return 7'b0000110;
            4'h2:    return 7'b1011011;
            4'h3:    return 7'b1001111;
            4'h4:    return 7'b1100110;
            4'h5:    return 7'b1101101;
            4'h6:    return 7'b1111101;
            4'h7:    return 7'b0000111;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1101111;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b1111100;
            4'hC:    return 7'b0111001;
            4'hD:    return 7'b1011110;
            4'hE:    return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    logic [PRESCALE_W-1:0] cnt_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   num_q, num_d;
    logic [DIGITS-1:0]     dots_q, dots_d;
    logic                  blz_q, blz_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dot_q, dot_d;
    logic                  frame_start_q;
    logic                  tick, wrap, nonzero_above, blank;

    // Next slot's digit and its decode; on a wrap the freshly sampled inputs feed the decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        tick          = &cnt_q;
        wrap          = tick && (idx_q == LAST_IDX);
        idx_d         = idx_q;
        num_d         = num_q;
        dots_d        = dots_q;
        blz_d         = blz_q;
        nonzero_above = 1'b0;
        an_d          = '0;
        seg_d         = '0;
        dot_d         = 1'b0;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
        if (wrap) begin
            num_d  = number;
            dots_d = dots;
            blz_d  = blank_lz;
        end
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_d) && (num_d[4*j +: 4] != 4'h0 || dots_d[j])) nonzero_above = 1'b1;
        end
        blank = blz_d && (idx_d != '0) && !nonzero_above;
        if (!blank) begin
            an_d[idx_d] = 1'b1;
            seg_d       = hex_to_seg(num_d[4*idx_d +: 4]);
            dot_d       = dots_d[idx_d];
        end
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= LAST_IDX;
            num_q         <= '0;
            dots_q        <= '0;
            blz_q         <= 1'b0;
            an_q          <= '0;
            seg_q         <= '0;
            dot_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q         <= cnt_q + 1'b1;
            idx_q         <= idx_d;
            num_q         <= num_d;
            dots_q        <= dots_d;
            blz_q         <= blz_d;
            frame_start_q <= wrap;
            if (tick) begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dot_q <= dot_d;
            end
        end
    end

`ifdef HEX_DISPLAY_BRIGHTNESS_EN
    logic [3:0] bright_q;
    logic       lit;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n)    bright_q <= '0;
        else if (wrap) bright_q <= brightness;
    end

    // PWM within a slot: the top four prescaler bits act as the duty phase.
    assign lit = (cnt_q[PRESCALE_W-1 -: 4] < bright_q);
`else
    logic lit;
    logic unused_brightness;

    assign lit               = 1'b1;
    assign unused_brightness = ^brightness;
`endif

    assign anodes         = (an_q & {DIGITS{lit}}) ^ {DIGITS{AN_ACTIVE_LOW}};
    assign seven_segments = (seg_q & {7{lit}}) ^ {7{SEG_ACTIVE_LOW}};
    assign dot            = (dot_q & lit) ^ SEG_ACTIVE_LOW;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_sm_hex_display_n.sv
// Scoreboard bench for sm_hex_display_n (DIGITS=8, PRESCALE_W=4, active-low anodes and segments).
module tb_sm_hex_display_n;

    localparam int DIGITS = 8;
    localparam int PW     = 4;
    localparam int SLOT   = 16;

    // Logical {g..a} per hex value.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clkIn = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] number = '0;
    logic [7:0]  dots = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [7:0]  anodes;
    logic        frame_start;

    sm_hex_display_n #(
        .DIGITS(DIGITS), .PRESCALE_W(PW), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clkIn(clkIn), .rst_n(rst_n), .number(number), .dots(dots),
        .blank_lz(blank_lz), .brightness(brightness), .seven_segments(seven_segments),
        .dot(dot), .anodes(anodes), .frame_start(frame_start)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        string       tag;
        int          slot;
        logic [15:0] exp;   // {anodes, seven_segments, dot} at the pins
    } exp_t;

    exp_t sb_q[$];
    int   errors   = 0;
    int   checks   = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [31:0] num, input logic [7:0] dts,
                                          input logic blz, input int i);
        logic [3:0] nib;
        logic       blank;
        nib   = num[4*i +: 4];
        blank = blz && (i > 0) && ((num >> (4*i)) == 32'h0) && ((dts >> i) == 8'h0);
        if (blank) return {8'hFF, 7'h7F, 1'b1};
        return {~(8'h01 << i), ~SEG_TBL[nib], ~dts[i]};
    endfunction

    task automatic push_frame(input string tag, input logic [31:0] num, input logic [7:0] dts,
                              input logic blz);
        for (int i = 0; i < DIGITS; i++) sb_q.push_back('{tag, i, model(num, dts, blz, i)});
    endtask

    // Monitor: on each frame_start with expectations pending, check all slots of that frame.
    initial begin
        forever begin
            @(negedge clkIn);
            if (rst_n && frame_start && sb_q.size() > 0) begin
                mon_busy = 1'b1;
                for (int s = 0; s < DIGITS; s++) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("%s slot%0d", e.tag, e.slot),
                          {16'h0, anodes, seven_segments, dot}, {16'h0, e.exp});
                    if (s == 0) begin
                        @(negedge clkIn);
                        check($sformatf("%s frame_start width", e.tag), {31'h0, frame_start}, 32'h0);
                        repeat (SLOT - 1) @(negedge clkIn);
                    end else if (s < DIGITS - 1) begin
                        repeat (SLOT) @(negedge clkIn);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clkIn);
            n++;
        end while (!frame_start && n < 400);
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_start not seen within 400 cycles", name);
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] num, input logic [7:0] dts,
                         input logic blz, input int skip_slots);
        wait_fs(tag);
        #2;
        repeat (skip_slots * SLOT) @(negedge clkIn);
        number   = num;
        dots     = dts;
        blank_lz = blz;
        push_frame(tag, num, dts, blz);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() > 0 || mon_busy) && n < 1000) begin
            @(negedge clkIn);
            n++;
        end
        if (sb_q.size() > 0 || mon_busy) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d expectations still pending", name, sb_q.size());
        end
    endtask

    // Assert reset at a falling clock edge for one cycle, then time the first frame_start.
    task automatic reset_pulse(input string tag);
        int n;
        bit active_seen;
        rst_n = 1'b0;
        #1;
        check({tag, " reset outputs"}, {15'h0, anodes, seven_segments, dot, frame_start},
              {15'h0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        @(negedge clkIn);
        rst_n = 1'b1;
        push_frame({tag, "_frame"}, number, dots, blank_lz);
        n = 0;
        active_seen = 1'b0;
        do begin
            @(negedge clkIn);
            n++;
            if (!frame_start && (anodes !== 8'hFF || seven_segments !== 7'h7F || dot !== 1'b1))
                active_seen = 1'b1;
        end while (!frame_start && n < 40);
        check({tag, " cycles to frame_start"}, n, 32'd16);
        check({tag, " inactive before frame"}, {31'h0, active_seen}, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clkIn);
        reset_pulse("por");

        apply("hex_89ab",  32'h89AB_CDEF, 8'h01, 1'b0, 0);
        apply("lz_a05",    32'h0000_0A05, 8'h00, 1'b1, 0);
        apply("lz_dot5",   32'h0000_0A05, 8'h20, 1'b1, 0);
        apply("pre_mid",   32'h0000_0001, 8'h00, 1'b0, 0);
        apply("mid_chg",   32'h0000_0002, 8'h00, 1'b0, 3);
        apply("mid_chg2",  32'hFFFF_FFFF, 8'hF0, 1'b0, 2);
        apply("lz_zero",   32'h0000_0000, 8'h00, 1'b1, 0);
        apply("all_dots",  32'h1234_5678, 8'hFF, 1'b1, 0);
        drain("drain1");

        wait_fs("pre_rst");
        repeat (4 * SLOT + 5) @(negedge clkIn);
        check("slot4 before reset", {24'h0, anodes}, 32'h0000_00EF);
        reset_pulse("mid_rst");
        drain("drain2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
